// File: rtl/kp_pkg.sv
// Shared types and constants for the Simon keypad encoder: FSM states,
// special key codes and the [row][col] key map.
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] KEY_STOP = 4'd10;
  localparam logic [3:0] KEY_GO   = 4'd11;
  localparam logic [3:0] KEY_LOCK = 4'd12;
  localparam logic [3:0] KEY_PWR  = 4'd13;
  localparam logic [3:0] KEY_ENT  = 4'd14;
  localparam logic [3:0] KEY_ESC  = 4'd15;

  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'd1,    4'd2, 4'd3,    KEY_STOP},
    '{4'd4,    4'd5, 4'd6,    KEY_GO},
    '{4'd7,    4'd8, 4'd9,    KEY_LOCK},
    '{KEY_ESC, 4'd0, KEY_ENT, KEY_PWR}
  };

  // Active-low one-cold column drive for column idx.
  function automatic logic [3:0] col_drive(logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Lowest-numbered row reading low; only meaningful when some row is low.
  function automatic logic [1:0] low_row(logic [3:0] r);
    low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/kpencode_sync2.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
// Resets to RST_VAL so idle pulled-up rows never look pressed.
module sync2 #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/kpencode.sv
// 4x4 keypad scanner/debouncer: walks one active-low column at a time,
// debounces the first low row found and reports its key code.
module kpencode
  import kp_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] num,
  output logic       kphit,
  output logic       kpress
);

  localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SET_TC = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] rs;

  sync2 #(.W(4), .RST_VAL(4'hF)) u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (rows),
    .q_o   (rs)
  );

  kp_state_t     state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cols_q, cols_d;
  logic [3:0]    num_q, num_d;
  logic          kphit_q, kphit_d;
  logic          kpress_q, kpress_d;
  logic          key_up;

  // Only the captured row bit matters once a key is being tracked.
  assign key_up = rs[row_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    kphit_d  = kphit_q;
    kpress_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q >= SET_TC) begin
          cnt_d = '0;
          if (rs != 4'hF) begin
            row_d   = low_row(rs);
            state_d = DEBOUNCE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (key_up) begin
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = SCAN;
        end else if (cnt_q >= DEB_TC) begin
          cnt_d    = '0;
          num_d    = KEY_MAP[row_q][idx_q];
          kphit_d  = 1'b1;
          kpress_d = 1'b1;
          state_d  = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (key_up) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!key_up) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q >= DEB_TC) begin
          cnt_d   = '0;
          kphit_d = 1'b0;
          idx_d   = idx_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
    // Registered from next index so a column change shows the cycle after terminal count.
    cols_d = col_drive(idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SCAN;
      idx_q    <= 2'd0;
      row_q    <= 2'd0;
      cnt_q    <= '0;
      cols_q   <= 4'b1110;
      num_q    <= 4'd0;
      kphit_q  <= 1'b0;
      kpress_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      cols_q   <= cols_d;
      num_q    <= num_d;
      kphit_q  <= kphit_d;
      kpress_q <= kpress_d;
    end
  end

  assign cols   = cols_q;
  assign num    = num_q;
  assign kphit  = kphit_q;
  assign kpress = kpress_q;

endmodule
